// File: rtl/ahb3_liten_pkg.sv
// Shared types and helpers for the ahb3_liten AHB3-Lite memory slave:
// transfer encodings, size/response constants, FSM states and lane enables.
package ahb3_liten_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_t;

   // Little-endian lane enables for an aligned transfer of the given size.
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << addr_lo;
         HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb3_liten_mem.sv
// Word-organised RAM for ahb3_liten: one 8-bit array per byte lane so each
// lane write enable maps onto its own memory, synchronous write, combinational read.
module ahb3_liten_mem #(
   parameter  int MEM_DEPTH = 1024,
   localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic          clk,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [MEM_DEPTH];

         always_ff @(posedge clk) begin
            if (we_i[gi]) begin
               lane_mem[addr_i] <= wdata_i[gi*8 +: 8];
            end
         end

         assign rdata_o[gi*8 +: 8] = lane_mem[addr_i];
      end
   endgenerate

endmodule

// File: rtl/ahb3_liten.sv
// AHB3-Lite single-port memory slave with two-cycle ERROR responses.
// Optional build macro AHB3_LITEN_WAIT_EN adds one wait state to every legal transfer.
module ahb3_liten
   import ahb3_liten_pkg::*;
#(
   parameter int MEM_DEPTH = 1024
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [15:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [16:0] MEM_BYTES = 17'(MEM_DEPTH * 4);

`ifdef AHB3_LITEN_WAIT_EN
   localparam state_t LEGAL_ST = ST_WAIT;
`else
   localparam state_t LEGAL_ST = ST_DATA;
`endif

   state_t      state_q, state_d;
   logic [15:0] addr_q;
   logic        write_q;
   logic [2:0]  size_q;

   htrans_t     htrans;
   logic        slot_open;
   logic        accept;
   logic        illegal;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic [3:0]  ram_we;
   logic [31:0] ram_rdata;
   logic        unused_bits;

   assign htrans    = htrans_t'(HTRANS);
   // Addresses are only captured in states where this slave drives HREADYOUT high.
   assign slot_open = (state_q != ST_WAIT) && (state_q != ST_ERR1);
   assign accept    = HSEL && HREADY && slot_open &&
                      ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
   assign illegal   = (HSIZE > HSIZE_WORD) ||
                      ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) ||
                      ({1'b0, HADDR} >= MEM_BYTES);

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= HSIZE_BYTE;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;
      hrdata    = '0;
      ram_we    = '0;
      case (state_q)
         ST_WAIT: begin
            hreadyout = 1'b0;
            state_d   = ST_DATA;
         end
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         default: begin
            if (state_q == ST_ERR2) begin
               hresp = HRESP_ERROR;
            end
            if (state_q == ST_DATA) begin
               // A reset landing on the completing cycle must not disturb the RAM.
               if (write_q && HRESETn) begin
                  ram_we = byte_en(size_q, addr_q[1:0]);
               end else if (!write_q) begin
                  hrdata = ram_rdata;
               end
            end
            if (accept) begin
               state_d = illegal ? ST_ERR1 : LEGAL_ST;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   ahb3_liten_mem #(
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk     (HCLK),
      .we_i    (ram_we),
      .addr_i  (addr_q[AW+1:2]),
      .wdata_i (HWDATA),
      .rdata_o (ram_rdata)
   );

   assign HREADYOUT   = hreadyout;
   assign HRESP       = hresp;
   assign HRDATA      = hrdata;
   assign unused_bits = ^{HBURST, HPROT, addr_q};

endmodule

// File: tb/tb_ahb3_liten.sv
// Self-checking bench for ahb3_liten: pipelined bus driver with a byte-level
// memory model, directed scenarios plus randomized traffic.
module tb_ahb3_liten;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [15:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   assign HREADY = HREADYOUT;

   always #5 HCLK = ~HCLK;

   ahb3_liten #(.MEM_DEPTH(1024)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HPROT     (HPROT),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP)
   );

`ifdef AHB3_LITEN_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif
   localparam int MEM_BYTES = 4096;

   typedef struct {
      bit        sel;
      bit [1:0]  trans;
      bit        wr;
      bit [2:0]  size;
      bit [15:0] addr;
      bit [31:0] wdata;
   } xfer_t;

   xfer_t       q[$];
   logic [7:0]  mem_b [MEM_BYTES];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] last_rdata;
   int          n_lowrdy;
   int          n_err;

   function automatic bit is_legal(xfer_t x);
      int nb;
      if (x.size > 3'd2) return 1'b0;
      nb = 1 << x.size;
      if ((int'(x.addr) % nb) != 0) return 1'b0;
      return int'(x.addr) < MEM_BYTES;
   endfunction

   function automatic logic [31:0] model_word(bit [15:0] a);
      int b;
      b = int'(a) & ~3;
      return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
   endfunction

   function automatic xfer_t mk(bit sel, bit [1:0] tr, bit wr, bit [2:0] sz,
                                bit [15:0] a, bit [31:0] d);
      xfer_t x;
      x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = d;
      return x;
   endfunction

   task automatic drive_idle();
      HSEL   = 1'b0;
      HTRANS = 2'd0;
      HWRITE = 1'b0;
      HSIZE  = 3'd0;
      HADDR  = 16'h0;
   endtask

   // Issues every queued transfer with full AHB pipelining and checks each
   // cycle's response against what the model says it must be.
   task automatic run_queue(input string tag);
      bit    dp_valid = 1'b0;
      bit    dp_legal = 1'b0;
      int    dp_stage = 0;
      xfer_t dp;
      xfer_t cur;
      bit    e_rdy, e_resp;
      logic [31:0] e_rdata;
      int    budget = 4000;
      n_lowrdy = 0;
      n_err    = 0;
      while ((q.size() > 0 || dp_valid) && budget > 0) begin
         budget--;
         @(posedge HCLK); #1;
         HWDATA = (dp_valid && dp.wr) ? dp.wdata : $urandom();
         HBURST = 3'($urandom());
         HPROT  = 4'($urandom());
         if (q.size() > 0) begin
            HSEL = q[0].sel; HTRANS = q[0].trans; HWRITE = q[0].wr;
            HSIZE = q[0].size; HADDR = q[0].addr;
         end else begin
            drive_idle();
         end
         @(negedge HCLK);
         e_rdy = 1'b1; e_resp = 1'b0; e_rdata = 32'h0;
         if (dp_valid && !dp_legal) begin
            e_resp = 1'b1;
            e_rdy  = (dp_stage != 0);
         end else if (dp_valid) begin
            if (WAIT_EN && dp_stage == 0) e_rdy = 1'b0;
            else if (!dp.wr) e_rdata = model_word(dp.addr);
         end
         if (HREADYOUT === 1'b0) n_lowrdy++;
         if (HRESP === 1'b1) n_err++;
         n_checks++;
         if (HREADYOUT !== e_rdy) $display("FAIL %s hreadyout addr=%h got %b exp %b", tag, dp.addr, HREADYOUT, e_rdy);
         else n_pass++;
         n_checks++;
         if (HRESP !== e_resp) $display("FAIL %s hresp addr=%h got %b exp %b", tag, dp.addr, HRESP, e_resp);
         else n_pass++;
         n_checks++;
         if (HRDATA !== e_rdata) $display("FAIL %s hrdata addr=%h got %h exp %h", tag, dp.addr, HRDATA, e_rdata);
         else n_pass++;
         if (e_rdy) begin
            if (dp_valid) begin
               $display("[%s] %s addr=%h size=%0d wdata=%h rdata=%h resp=%s", tag,
                        dp.wr ? "WR" : "RD", dp.addr, dp.size, dp.wdata, HRDATA,
                        dp_legal ? "OKAY" : "ERROR");
               if (dp_legal && dp.wr) begin
                  for (int i = 0; i < (1 << dp.size); i++) begin
                     int a;
                     a = int'(dp.addr) + i;
                     mem_b[a] = dp.wdata[8*(a % 4) +: 8];
                  end
               end
               if (dp_legal && !dp.wr) last_rdata = HRDATA;
            end
            if (q.size() > 0) begin
               cur      = q.pop_front();
               dp       = cur;
               dp_valid = cur.sel && cur.trans[1];
               dp_legal = is_legal(cur);
               dp_stage = 0;
            end else begin
               dp_valid = 1'b0;
            end
         end else begin
            dp_stage++;
         end
      end
      if (budget == 0) begin
         n_checks++;
         $display("FAIL %s timeout remaining=%0d required=0", tag, q.size());
         q.delete();
      end
      @(posedge HCLK); #1;
      drive_idle();
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      drive_idle();
      HWDATA = '0; HBURST = '0; HPROT = '0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      n_checks++;
      if (HREADYOUT !== 1'b1) $display("FAIL reset_hreadyout got %b exp 1", HREADYOUT); else n_pass++;
      n_checks++;
      if (HRESP !== 1'b0) $display("FAIL reset_hresp got %b exp 0", HRESP); else n_pass++;
      n_checks++;
      if (HRDATA !== 32'h0) $display("FAIL reset_hrdata got %h exp 0", HRDATA); else n_pass++;
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
   endtask

   task automatic test_init();
      for (int w = 0; w < 64; w++) q.push_back(mk(1, 2'd2, 1, 3'd2, 16'(w * 4), $urandom()));
      q.push_back(mk(1, 2'd2, 1, 3'd2, 16'h0FFC, $urandom()));
      run_queue("init");
   endtask

   task automatic test_word_rw();
      q.push_back(mk(1, 2'd2, 1, 3'd2, 16'h0010, 32'hDEADBEEF));
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0010, 32'h0));
      run_queue("word_rw");
      n_checks++;
      if (last_rdata !== 32'hDEADBEEF) $display("FAIL word_rw_data got %h exp deadbeef", last_rdata);
      else n_pass++;
   endtask

   task automatic test_byte_half();
      q.push_back(mk(1, 2'd2, 1, 3'd2, 16'h0020, 32'h00000000));
      q.push_back(mk(1, 2'd2, 1, 3'd0, 16'h0021, 32'h0000AB00));
      q.push_back(mk(1, 2'd3, 1, 3'd1, 16'h0022, 32'h12340000));
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0020, 32'h0));
      run_queue("byte_half");
      n_checks++;
      if (last_rdata !== 32'h1234AB00) $display("FAIL byte_half_data got %h exp 1234ab00", last_rdata);
      else n_pass++;
   endtask

   task automatic test_misaligned();
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0002, 32'h0));
      q.push_back(mk(1, 2'd2, 1, 3'd1, 16'h0013, 32'h55550000));
      q.push_back(mk(1, 2'd2, 0, 3'd5, 16'h0010, 32'h0));
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0010, 32'h0));
      run_queue("misaligned");
      n_checks++;
      if (n_err !== 6) $display("FAIL misaligned_err_cycles got %0d exp 6", n_err); else n_pass++;
      n_checks++;
      if (last_rdata !== 32'hDEADBEEF) $display("FAIL misaligned_no_write got %h exp deadbeef", last_rdata);
      else n_pass++;
   endtask

   task automatic test_out_of_range();
      q.push_back(mk(1, 2'd2, 1, 3'd2, 16'h1000, 32'hFFFFFFFF));
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0000, 32'h0));
      q.push_back(mk(1, 2'd2, 1, 3'd2, 16'h0FFC, 32'hA5A55A5A));
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0FFC, 32'h0));
      run_queue("out_of_range");
      n_checks++;
      if (n_err !== 2) $display("FAIL oor_err_cycles got %0d exp 2", n_err); else n_pass++;
      n_checks++;
      if (last_rdata !== 32'hA5A55A5A) $display("FAIL oor_top_word got %h exp a5a55a5a", last_rdata);
      else n_pass++;
   endtask

   task automatic test_idle_deselect();
      q.push_back(mk(1, 2'd0, 1, 3'd2, 16'h0010, 32'h11111111));
      q.push_back(mk(0, 2'd2, 1, 3'd2, 16'h0010, 32'h22222222));
      q.push_back(mk(1, 2'd1, 1, 3'd2, 16'h0010, 32'h33333333));
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0010, 32'h0));
      run_queue("idle_desel");
      n_checks++;
      if (last_rdata !== 32'hDEADBEEF) $display("FAIL idle_desel_data got %h exp deadbeef", last_rdata);
      else n_pass++;
   endtask

   task automatic test_wait_states();
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0020, 32'h0));
      run_queue("wait_states");
      n_checks++;
      if (n_lowrdy !== (WAIT_EN ? 1 : 0))
         $display("FAIL wait_cycles got %0d exp %0d", n_lowrdy, WAIT_EN ? 1 : 0);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      @(posedge HCLK); #1;
      HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 16'h0030;
      @(posedge HCLK); #1;
      drive_idle();
      HWDATA  = 32'hCAFEF00D;
      HRESETn = 1'b0;
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(negedge HCLK);
      n_checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
         $display("FAIL reset_abort_resp got %b/%b exp 1/0", HREADYOUT, HRESP);
      else n_pass++;
      q.push_back(mk(1, 2'd2, 0, 3'd2, 16'h0030, 32'h0));
      run_queue("reset_abort");
      n_checks++;
      if (last_rdata === 32'hCAFEF00D) $display("FAIL reset_abort_write got %h exp old data", last_rdata);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         xfer_t x;
         int    r;
         x.sel   = ($urandom_range(0, 9) != 0);
         r       = $urandom_range(0, 9);
         x.trans = (r < 8) ? 2'(2 + (r % 2)) : 2'(r - 8);
         x.wr    = 1'($urandom());
         x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         x.addr  = 16'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0 && x.size <= 3'd2)
            x.addr = x.addr & ~16'((1 << x.size) - 1);
         if ($urandom_range(0, 19) == 0)
            x.addr = 16'($urandom_range(16'h1000, 16'hFFFF));
         x.wdata = $urandom();
         q.push_back(x);
      end
      run_queue("random");
   endtask

   initial begin
      last_rdata = '0;
      test_reset();
      test_init();
      test_word_rw();
      test_byte_half();
      test_misaligned();
      test_out_of_range();
      test_idle_deselect();
      test_wait_states();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
